serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/half_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: x - y with borrow out.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   // Purely combinational difference and borrow.
   always_comb begin
      d  = x ^ y;
      bo = ~x & y;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, with a
// valid/ready result handshake.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bw_q, bw_d;

   // Full-subtract cell built from two half subtractors.
   logic d1, bo1, d_bit, bo2, bw_nxt;

   half_subtractor u_hs0 (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .d  (d1),
      .bo (bo1)
   );

   half_subtractor u_hs1 (
      .x  (d1),
      .y  (bw_q),
      .d  (d_bit),
      .bo (bo2)
   );

   assign bw_nxt = bo1 | bo2;

   // Next-state, datapath update and status outputs.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      bw_d    = bw_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               bw_d    = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {d_bit, res_q[WIDTH-1:1]};
            bw_d  = bw_nxt;
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            // Start is ignored here; only the handshake leaves DONE.
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         bw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         bw_q    <= bw_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign out_valid  = (state_q == DONE);
   assign diff       = res_q;
   assign borrow_out = bw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         borrow_out;

   int checks = 0;
   int errors = 0;
   logic [W:0] exp_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop the expected result whenever the DUT hands one over.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected result", 32'(out_valid), 32'(0));
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("result diff", 32'(diff), 32'(e[W-1:0]));
            chk("result borrow", 32'(borrow_out), 32'(e[W]));
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) chk("idle before start timeout", 32'(busy), 32'(0));
      a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_q.push_back({eb, ed});
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) chk("out_valid timeout", 32'(out_valid), 32'(1));
   endtask

   // Hold out_ready low for 'hold' cycles checking stability, then hand over.
   task automatic drain(input int hold);
      logic [W-1:0] d0;
      logic         b0;
      wait_valid();
      d0 = diff; b0 = borrow_out;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold valid", 32'(out_valid), 32'(1));
         chk("hold diff", 32'(diff), 32'(d0));
         chk("hold borrow", 32'(borrow_out), 32'(b0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle after handshake", 32'(busy), 32'(0));
      chk("valid drops", 32'(out_valid), 32'(0));
      chk("diff kept", 32'(diff), 32'(d0));
      chk("borrow kept", 32'(borrow_out), 32'(b0));
   endtask

   initial begin
      // Reset state.
      #12;
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst valid", 32'(out_valid), 32'(0));
      chk("rst diff", 32'(diff), 32'(0));
      chk("rst borrow", 32'(borrow_out), 32'(0));
      @(posedge clk); #1;

      // Start accepted on the first edge after reset release; 5-3.
      rst_n = 1'b1;
      issue(8'd5, 8'd3, 8'd2, 1'b0);
      chk("busy after accept", 32'(busy), 32'(1));
      // Result shows up WIDTH edges after the accepting edge, i.e. in the
      // (WIDTH+1)th cycle counting the accepting cycle.
      for (int k = 1; k <= W; k++) begin
         @(posedge clk); #1;
         chk($sformatf("latency edge %0d", k), 32'(out_valid), 32'(k == W));
      end
      drain(0);

      // 3-5 with start pulses during SHIFT and DONE that must be ignored.
      issue(8'd3, 8'd5, 8'hFE, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      a = 8'hAA; b = 8'h11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_valid();
      a = 8'h40; b = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ignored start diff", 32'(diff), 32'(8'hFE));
      chk("ignored start valid", 32'(out_valid), 32'(1));
      // Start coincident with the handshake is ignored as well.
      out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; start = 1'b0;
      chk("start at handshake busy", 32'(busy), 32'(0));
      @(posedge clk); #1;
      chk("still idle", 32'(busy), 32'(0));

      // Boundary operands with a long stall.
      issue(8'd255, 8'd255, 8'd0, 1'b0);
      drain(5);
      issue(8'd0, 8'd255, 8'd1, 1'b1);
      drain(1);
      issue(8'h80, 8'h01, 8'h7F, 1'b0);
      drain(0);
      issue(8'h00, 8'h01, 8'hFF, 1'b1);
      drain(2);

      // Reset during the 4th SHIFT cycle aborts the operation.
      issue(8'h77, 8'h11, 8'h66, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      chk("abort busy", 32'(busy), 32'(0));
      chk("abort valid", 32'(out_valid), 32'(0));
      chk("abort diff", 32'(diff), 32'(0));
      chk("abort borrow", 32'(borrow_out), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(8'd10, 8'd4, 8'd6, 1'b0);
      drain(0);

      repeat (2) @(posedge clk);
      chk("scoreboard empty", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
